// File: rtl/vga_text_ctrl.sv
// Text-mode sequencer: 640x480@60 timing, 70x30 grid of 9x16 cells, frame-latched scroll and blinking cursor.
// ram_addr presents S0 cell address; char/h_font/v_font/c_valid/cursor valid in S1; hsync/vsync land in S2.
module vga_text_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [4:0]  scroll_row,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [7:0]  char,
  output logic [3:0]  h_font,
  output logic [3:0]  v_font,
  output logic        c_valid,
  output logic        cursor,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_TEXT = HW'(COLS * 9);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_TEXT = VW'(ROWS * 16);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [4:0]    ROWS5  = 5'(ROWS);
  localparam logic [6:0]    COLS7  = 7'(COLS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [3:0]    hf;
  logic [3:0]    vf;
  logic [6:0]    col;
  logic [4:0]    row;

  logic [4:0]    scroll_l;
  logic          cursor_en_l;
  logic [6:0]    cursor_col_l;
  logic [4:0]    cursor_row_l;
  logic          blink;
  logic [BW-1:0] blink_cnt;

  logic [11:0]   addr_q;
  logic          hs_p1;
  logic          vs_p1;

  logic          h_wrap;
  logic          frame_wrap;
  logic          text_area;
  logic [4:0]    scroll_adj;
  logic [5:0]    row_sum;
  logic [4:0]    phys_row;
  logic [11:0]   addr_calc;
  logic          cursor_hit;
  logic          hs_s0;
  logic          vs_s0;

  assign h_wrap     = (h_cnt == H_LAST);
  assign frame_wrap = h_wrap && (v_cnt == V_LAST);
  assign text_area  = (h_cnt < H_TEXT) && (v_cnt < V_TEXT);

  assign scroll_adj = (scroll_row >= ROWS5) ? (scroll_row - ROWS5) : scroll_row;
  assign row_sum    = {1'b0, row} + {1'b0, scroll_l};
  assign phys_row   = (row_sum >= {1'b0, ROWS5}) ? 5'(row_sum - {1'b0, ROWS5}) : row_sum[4:0];
  assign addr_calc  = ({7'd0, phys_row} * {5'd0, COLS7}) + {5'd0, col};

  // Outside the text area the address freezes so the RAM is not toggled needlessly.
  assign ram_addr   = text_area ? addr_calc : addr_q;
  assign char       = ram_data;

  assign cursor_hit = text_area && cursor_en_l && blink &&
                      (col == cursor_col_l) && (row == cursor_row_l);
  assign hs_s0      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_s0      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  always_ff @(posedge pclk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hf    <= '0;
      vf    <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;

      if (h_wrap) begin
        hf  <= '0;
        col <= '0;
      end else if (h_cnt < H_TEXT) begin
        if (hf == 4'd8) begin
          hf  <= '0;
          col <= col + 7'd1;
        end else begin
          hf  <= hf + 4'd1;
        end
      end

      if (frame_wrap) begin
        v_cnt <= '0;
        vf    <= '0;
        row   <= '0;
      end else if (h_wrap) begin
        v_cnt <= v_cnt + 1'b1;
        if (v_cnt < V_TEXT) begin
          vf <= vf + 4'd1;
          if (vf == 4'd15) row <= row + 5'd1;
        end
      end
    end
  end

  // Display controls only change at the frame boundary to avoid tearing.
  always_ff @(posedge pclk) begin
    if (rst) begin
      scroll_l     <= '0;
      cursor_en_l  <= 1'b0;
      cursor_col_l <= '0;
      cursor_row_l <= '0;
      blink        <= 1'b1;
      blink_cnt    <= '0;
    end else if (frame_wrap) begin
      scroll_l     <= scroll_adj;
      cursor_en_l  <= cursor_en;
      cursor_col_l <= cursor_col;
      cursor_row_l <= cursor_row;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      addr_q      <= '0;
      h_font      <= '0;
      v_font      <= '0;
      c_valid     <= 1'b0;
      cursor      <= 1'b0;
      hs_p1       <= 1'b1;
      vs_p1       <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      addr_q      <= ram_addr;
      h_font      <= hf;
      v_font      <= vf;
      c_valid     <= text_area;
      cursor      <= cursor_hit;
      hs_p1       <= hs_s0;
      vs_p1       <= vs_s0;
      hsync       <= hs_p1;
      vsync       <= vs_p1;
      // Registered so it is high exactly while S0 sits at h=0, v=0, but never straight out of reset.
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Randomized bench for vga_text_ctrl on a scaled-down raster, compared each cycle to a
// position-arithmetic reference model (pixel index -> h/v/frame by division and modulo).
module tb_vga_text_ctrl;

  localparam int H_ACTIVE = 72;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 64;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int COLS     = 7;
  localparam int ROWS     = 4;
  localparam int BLINK    = 2;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;
  localparam int TW = COLS * 9;
  localparam int TH = ROWS * 16;

  logic        pclk;
  logic        rst;
  logic [4:0]  scroll_row;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic [7:0]  char_o;
  logic [3:0]  h_font;
  logic [3:0]  v_font;
  logic        c_valid;
  logic        cursor;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  logic [7:0]  mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int m_addr   = 0;
  int lat_scroll [0:15];
  int lat_cen    [0:15];
  int lat_ccol   [0:15];
  int lat_crow   [0:15];

  vga_text_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BLINK)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .scroll_row(scroll_row),
    .cursor_en(cursor_en),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .char(char_o),
    .h_font(h_font),
    .v_font(v_font),
    .c_valid(c_valid),
    .cursor(cursor),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Synchronous text RAM: data one cycle after address.
  always @(posedge pclk) ram_data <= mem[ram_addr];

  function automatic int hpos(input int c);
    return c % HT;
  endfunction

  function automatic int vpos(input int c);
    return (c / HT) % VT;
  endfunction

  function automatic int fidx(input int c);
    return c / FT;
  endfunction

  function automatic bit in_text(input int c);
    return (hpos(c) < TW) && (vpos(c) < TH);
  endfunction

  function automatic bit blink_on(input int f);
    return ((f / BLINK) % 2) == 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_addr = 0;
    for (int i = 0; i < 16; i++) begin
      lat_scroll[i] = 0;
      lat_cen[i]    = 0;
      lat_ccol[i]   = 0;
      lat_crow[i]   = 0;
    end
  endtask

  task automatic check_cycle();
    int h, v, f, p, ph, pv, pf, prev_addr, sh, sv;
    bit exp_cur;
    h = hpos(k);
    v = vpos(k);
    f = fidx(k);
    prev_addr = m_addr;
    if (in_text(k)) m_addr = (((v / 16) + lat_scroll[f]) % ROWS) * COLS + h / 9;
    check_val("ram_addr", 32'(ram_addr), 32'(m_addr));
    check_val("frame_start", 32'(frame_start), 32'(k > 0 && h == 0 && v == 0));
    if (k == 0) begin
      check_val("h_font_rst", 32'(h_font), 32'd0);
      check_val("v_font_rst", 32'(v_font), 32'd0);
      check_val("c_valid_rst", 32'(c_valid), 32'd0);
      check_val("cursor_rst", 32'(cursor), 32'd0);
    end else begin
      p  = k - 1;
      ph = hpos(p);
      pv = vpos(p);
      pf = fidx(p);
      check_val("h_font", 32'(h_font), 32'((ph < TW) ? ph % 9 : 0));
      check_val("v_font", 32'(v_font), 32'((pv < TH) ? pv % 16 : 0));
      check_val("c_valid", 32'(c_valid), 32'(in_text(p)));
      exp_cur = in_text(p) && (lat_cen[pf] != 0) && blink_on(pf) &&
                (ph / 9 == lat_ccol[pf]) && (pv / 16 == lat_crow[pf]);
      check_val("cursor", 32'(cursor), 32'(exp_cur));
      check_val("char", 32'(char_o), 32'(mem[prev_addr]));
    end
    if (k < 2) begin
      check_val("hsync_rst", 32'(hsync), 32'd1);
      check_val("vsync_rst", 32'(vsync), 32'd1);
    end else begin
      sh = hpos(k - 2);
      sv = vpos(k - 2);
      check_val("hsync", 32'(hsync), 32'(!(sh >= H_ACTIVE + H_FP && sh < H_ACTIVE + H_FP + H_SYNC)));
      check_val("vsync", 32'(vsync), 32'(!(sv >= V_ACTIVE + V_FP && sv < V_ACTIVE + V_FP + V_SYNC)));
    end
  endtask

  task automatic randomize_controls();
    scroll_row = 5'($urandom_range(0, 2 * ROWS - 1));
    cursor_en  = ($urandom_range(0, 3) != 0);
    cursor_col = 7'($urandom_range(0, COLS + 2));
    cursor_row = 5'($urandom_range(0, ROWS + 1));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      if ($urandom_range(0, 299) == 0) randomize_controls();
      if (hpos(k) == HT - 1 && vpos(k) == VT - 1) begin
        lat_scroll[fidx(k) + 1] = int'(scroll_row);
        lat_cen[fidx(k) + 1]    = int'(cursor_en);
        lat_ccol[fidx(k) + 1]   = int'(cursor_col);
        lat_crow[fidx(k) + 1]   = int'(cursor_row);
      end
      @(negedge pclk);
      k++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    rst        = 1'b1;
    scroll_row = '0;
    cursor_en  = 1'b1;
    cursor_col = 7'd2;
    cursor_row = 5'd1;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    model_reset();

    run_cycles(3 * FT + 1234);

    // Single-cycle reset in the middle of a frame.
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    cursor_en  = 1'b1;
    cursor_col = 7'd3;
    cursor_row = 5'd2;
    run_cycles(4 * FT + 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
Text-mode sequencer for the ASCII glyph renderer. It generates 640x480@60 timing on pclk and walks a 70x30 grid of 9x16 character cells. It fetches each cell's code from the synchronous text RAM and drives the renderer's char, h_font, v_font, c_valid and cursor inputs, pipelined so that hsync/vsync line up with the renderer's registered vga_data. It also provides frame-latched hardware scroll and a blinking cursor.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
COLS, 70, text columns (9 px each; 630 px text area)
ROWS, 30, text rows (16 lines each)
BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
scroll_row  in  5  RAM row shown on screen row 0, 0..ROWS-1
cursor_en  in  1  cursor display enable
cursor_col  in  7  cursor column (screen coordinates)
cursor_row  in  5  cursor row (screen coordinates)
ram_addr  out  12  text RAM read address
ram_data  in  8  text RAM read data, valid 1 cycle after ram_addr
char  out  8  glyph code to renderer (= ram_data, combinational)
h_font  out  4  pixel column in cell, 0..8
v_font  out  4  pixel row in cell, 0..15
c_valid  out  1  pixel lies in text area
cursor  out  1  pixel lies in the visible cursor cell
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
frame_start  out  1  one-cycle pulse at h=0, v=0 (stage S0)

Behaviour:
- Reset values: all counters 0; blink phase 1 (visible); blink counter 0; ram_addr 0; h_font 0; v_font 0; c_valid 0; cursor 0; hsync 1; vsync 1; frame_start 0; latched scroll/cursor values 0/0/0/disabled.
- Stage S0 counters: h_cnt 0..799 increments every cycle and wraps to 0; v_cnt 0..524 increments on the h wrap and wraps to 0.
- Cell counters are incremental, with no dividers. hf 0..8 and col advance while h_cnt<630 and reset at h_cnt=799. vf 0..15 and row advance on the h wrap while v_cnt<480 and reset at the frame wrap.
- text_area = h_cnt<630 && v_cnt<480. Pixels at h 630..639 are active but outside the text area.
- Frame latch: on h_cnt=799 && v_cnt=524, capture scroll_row, cursor_en, cursor_col and cursor_row. Changes mid-frame have no effect until the next frame.
- Address: phys_row = row+scroll_l, minus ROWS if the sum is >= ROWS. ram_addr = phys_row*COLS+col, registered into the RAM so the RAM samples S0 values. When not in text_area, ram_addr holds its last value.
- Stage S1 (one pclk after S0): h_font<=hf, v_font<=vf, c_valid<=text_area.
- cursor<=text_area & cursor_en_l & blink & (col==cursor_col_l) & (row==cursor_row_l). The renderer picks the cursor column within the cell.
- char equals ram_data during S1.
- Stage S2: the renderer registers vga_data. hsync and vsync are delayed two cycles so they land in S2.
  - hsync=0 when the S0 h_cnt was in 656..751.
  - vsync=0 when the S0 v_cnt was in 490..491.
- Blink: the frame counter increments on each frame wrap. When it reaches BLINK_FRAMES-1 it clears and blink toggles.
- cursor_col >= COLS or cursor_row >= ROWS: cursor never asserts. No error is raised.
- scroll_row >= ROWS: treated as scroll_row-ROWS before latching.
- Reset mid-frame: the cycle after rst=1, every state and output is at its reset value. Timing restarts from h=0, v=0 once rst drops.

Test Plan:
- Release reset and run 2 frames -> line period 800 cycles; frame period 420000 cycles; hsync low for 96 cycles starting at cycle 658 after release (S0 656 + 2); vsync low for 1600 cycles.
- scroll_row=0, S0 at h=48, v=39 -> ram_addr=145 (row 2, col 5). Next cycle: h_font=3, v_font=7, c_valid=1, char=RAM[145].
- scroll_row=29 latched -> screen row 0 fetches address 2030+col; screen row 1, col 0 fetches address 0.
- S0 at h=630..639 and at v>=480 -> c_valid=0 and cursor=0 one cycle later.
- cursor_en=1, col 10, row 3 -> cursor=1 for exactly 9 cycles per line across 16 lines. It is visible for 30 frames, off for 30 frames, then repeats. A cursor_col change mid-frame takes effect only the next frame.
- Assert rst for 1 cycle at h=300, v=200 -> next cycle: hsync=1, vsync=1, c_valid=0, ram_addr=0. After release, the first hsync falls 658 cycles later.
